dbank_arbiter: RTL

DBANK_ARBITER -- requirements
Module: dbank_arbiter

---
 rtl/dbank_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/dbank_arbiter.sv
// Dual-bank port arbiter: operand reads, 2-deep writeback FIFO and bank-to-bank moves.
// Optional ARB_STALL_CNT_EN adds a saturating read-stall cycle counter (stall_cnt).
module dbank_arbiter #(
    parameter int unsigned DW = 256,
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd_valid,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_x,
    output logic          rd_ready,
    output logic          rd_dvalid,
    output logic [DW-1:0] rd_data_a,
    output logic [DW-1:0] rd_data_x,
    input  logic          wb_valid,
    input  logic          wb_bank,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          wb_ready,
    input  logic          mv_valid,
    input  logic          mv_src_bank,
    input  logic [AW-1:0] mv_src_addr,
    input  logic [AW-1:0] mv_dst_addr,
    output logic          mv_ready,
    output logic          mv_done,
    output logic          W_d1,
    output logic          W_d2,
    output logic [AW-1:0] addr_d1,
    output logic [AW-1:0] addr_d2,
    output logic [DW-1:0] Dout_d1,
    output logic [DW-1:0] Dout_d2,
    input  logic [DW-1:0] Din_c1,
    input  logic [DW-1:0] Din_c2
`ifdef ARB_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    typedef enum logic [0:0] {StIdle, StMvWr} state_e;

    state_e        r_state, w_state_d;
    logic [1:0]    r_count;
    logic [1:0]    w_count_d;
    logic          r_wr_ptr, r_rd_ptr;
    logic          r_fifo_bank [2];
    logic [AW-1:0] r_fifo_addr [2];
    logic [DW-1:0] r_fifo_data [2];
    logic          r_wb_ready;
    logic          r_rd_dvalid;
    logic          r_mv_done;
    logic          r_mv_src_bank;
    logic [AW-1:0] r_mv_dst;
    logic          w_push, w_pop, w_mv_grant;

    assign w_push    = wb_valid && r_wb_ready;
    assign w_count_d = r_count + {1'b0, w_push} - {1'b0, w_pop};
    assign wb_ready  = r_wb_ready;
    assign rd_dvalid = r_rd_dvalid;
    assign mv_done   = r_mv_done;
    assign rd_data_a = r_rd_dvalid ? Din_c1 : '0;
    assign rd_data_x = r_rd_dvalid ? Din_c2 : '0;

    always_comb begin
        w_state_d  = r_state;
        w_pop      = 1'b0;
        w_mv_grant = 1'b0;
        rd_ready   = 1'b0;
        mv_ready   = 1'b0;
        W_d1       = 1'b1;
        W_d2       = 1'b1;
        addr_d1    = '0;
        addr_d2    = '0;
        Dout_d1    = '0;
        Dout_d2    = '0;
        case (r_state)
            StIdle: begin
                if (r_count == 2'd2) begin
                    w_pop = 1'b1;
                end else if (rd_valid) begin
                    rd_ready = 1'b1;
                    addr_d1  = rd_addr_a;
                    addr_d2  = rd_addr_x;
                end else if (r_count != 2'd0) begin
                    w_pop = 1'b1;
                end else if (mv_valid) begin
                    mv_ready   = 1'b1;
                    w_mv_grant = 1'b1;
                    w_state_d  = StMvWr;
                    if (mv_src_bank) addr_d1 = mv_src_addr;
                    else             addr_d2 = mv_src_addr;
                end
                if (w_pop) begin
                    if (r_fifo_bank[r_rd_ptr]) begin
                        W_d1    = 1'b0;
                        addr_d1 = r_fifo_addr[r_rd_ptr];
                        Dout_d1 = r_fifo_data[r_rd_ptr];
                    end else begin
                        W_d2    = 1'b0;
                        addr_d2 = r_fifo_addr[r_rd_ptr];
                        Dout_d2 = r_fifo_data[r_rd_ptr];
                    end
                end
            end
            StMvWr: begin
                // Source data arrives on Din this cycle; write it to the opposite bank.
                w_state_d = StIdle;
                if (r_mv_src_bank) begin
                    W_d2    = 1'b0;
                    addr_d2 = r_mv_dst;
                    Dout_d2 = Din_c1;
                end else begin
                    W_d1    = 1'b0;
                    addr_d1 = r_mv_dst;
                    Dout_d1 = Din_c2;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_count       <= 2'd0;
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_wb_ready    <= 1'b1;
            r_rd_dvalid   <= 1'b0;
            r_mv_done     <= 1'b0;
            r_mv_src_bank <= 1'b0;
            r_mv_dst      <= '0;
        end else begin
            r_state     <= w_state_d;
            r_count     <= w_count_d;
            r_wb_ready  <= (w_count_d != 2'd2);
            r_rd_dvalid <= rd_ready;
            r_mv_done   <= (r_state == StMvWr);
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            if (w_mv_grant) begin
                r_mv_src_bank <= mv_src_bank;
                r_mv_dst      <= mv_dst_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_bank[r_wr_ptr] <= wb_bank;
            r_fifo_addr[r_wr_ptr] <= wb_addr;
            r_fifo_data[r_wr_ptr] <= wb_data;
        end
    end

`ifdef ARB_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'd0;
        end else if (rd_valid && !rd_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
